// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V execute stage: ALU opcodes, FSM states,
// and the EX/MEM pipeline register layout with its bubble value.
package misc_v_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8;
    localparam logic [3:0] ALU_MUL = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ex_state_e;

    // EX/MEM register contents; a bubble is all zeros.
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic        data_in_sel;
        logic [1:0]  reg_store;
        logic [15:0] pcp2;
        logic [15:0] result;
        logic [15:0] third_arg;
        logic [2:0]  rd;
    } exmem_t;

    localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, low WIDTH
// bits kept. done is high during the final iteration; product is valid then.
module mul_iter #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(MUL_CYCLES);

    logic [WIDTH-1:0] r_a, r_b, r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_run;
    logic [WIDTH-1:0] w_partial, w_acc_next;

    assign w_partial  = r_b[r_cnt] ? (r_a << r_cnt) : '0;
    assign w_acc_next = r_acc + w_partial;
    assign done       = r_run && (r_cnt == CW'(MUL_CYCLES - 1));
    // Final product includes the last partial, so it is ready on the done edge.
    assign product    = w_acc_next;

    // Operand capture, accumulation and iteration count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (abort) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_acc_next;
            if (done) begin
                r_cnt <= '0;
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU, iterative MUL with upstream stall,
// synchronous flush, and the EX/MEM pipeline register.
module execute_stage
    import misc_v_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IValid,
    input  logic             IRegWrite,
    input  logic             IMemWrite,
    input  logic             IMemRead,
    input  logic             IDataInSelect,
    input  logic [1:0]       IRegStore,
    input  logic [3:0]       ALUOp,
    input  logic [WIDTH-1:0] IPCP2,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [WIDTH-1:0] IThirdArg,
    input  logic [2:0]       rdEx,
    input  logic             flush,
    output logic             stall,
    output logic             ORegWrite,
    output logic             OMemWrite,
    output logic             OMemRead,
    output logic             ODataInSelect,
    output logic [1:0]       ORegStore,
    output logic [WIDTH-1:0] OPCP2,
    output logic [WIDTH-1:0] OALUResult,
    output logic [WIDTH-1:0] thirdArg,
    output logic [2:0]       rdMem
);
    ex_state_e        r_state, w_state_nx;
    exmem_t           r_out, r_hold, w_out_nx, w_in;
    logic [WIDTH-1:0] w_alu, w_product;
    logic             w_start, w_abort, w_done, w_stall;

    assign w_in = '{reg_write: IRegWrite, mem_write: IMemWrite, mem_read: IMemRead,
                    data_in_sel: IDataInSelect, reg_store: IRegStore, pcp2: IPCP2,
                    result: '0, third_arg: IThirdArg, rd: rdEx};

    // Single-cycle ALU; unused opcodes (MUL included) produce 0.
    always_comb begin
        w_alu = '0;
        case (ALUOp)
            ALU_ADD: w_alu = OpA + OpB;
            ALU_SUB: w_alu = OpA - OpB;
            ALU_AND: w_alu = OpA & OpB;
            ALU_OR:  w_alu = OpA | OpB;
            ALU_XOR: w_alu = OpA ^ OpB;
            ALU_SLL: w_alu = OpA << OpB[3:0];
            ALU_SRL: w_alu = OpA >> OpB[3:0];
            ALU_SRA: w_alu = $signed(OpA) >>> OpB[3:0];
            ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(OpA) < $signed(OpB))};
            default: w_alu = '0;
        endcase
    end

    assign w_start = (r_state == ST_IDLE) && IValid && (ALUOp == ALU_MUL) && !flush;
    assign w_abort = (r_state == ST_BUSY) && flush;

    mul_iter #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst_n   (reset),
        .start   (w_start),
        .abort   (w_abort),
        .a       (OpA),
        .b       (OpB),
        .done    (w_done),
        .product (w_product)
    );

    // Next state, stall and next EX/MEM contents; flush forces a bubble.
    always_comb begin
        w_state_nx = r_state;
        w_out_nx   = EXMEM_BUBBLE;
        w_stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!flush && IValid) begin
                    if (ALUOp == ALU_MUL) begin
                        w_stall    = 1'b1;
                        w_state_nx = ST_BUSY;
                    end else begin
                        w_out_nx        = w_in;
                        w_out_nx.result = w_alu;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    w_state_nx = ST_IDLE;
                end else if (w_done) begin
                    w_out_nx        = r_hold;
                    w_out_nx.result = w_product;
                    w_state_nx      = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State, MUL pass-through capture and EX/MEM register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_hold  <= EXMEM_BUBBLE;
            r_out   <= EXMEM_BUBBLE;
        end else begin
            r_state <= w_state_nx;
            r_out   <= w_out_nx;
            if (w_start) r_hold <= w_in;
        end
    end

    // stall is masked by reset so it reads 0 while reset is asserted.
    assign stall         = w_stall && reset;
    assign ORegWrite     = r_out.reg_write;
    assign OMemWrite     = r_out.mem_write;
    assign OMemRead      = r_out.mem_read;
    assign ODataInSelect = r_out.data_in_sel;
    assign ORegStore     = r_out.reg_store;
    assign OPCP2         = r_out.pcp2;
    assign OALUResult    = r_out.result;
    assign thirdArg      = r_out.third_arg;
    assign rdMem         = r_out.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench: driver pushes expected stall / EX/MEM contents per cycle,
// monitor pops and compares at the falling edge.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        IValid, IRegWrite, IMemWrite, IMemRead, IDataInSelect, flush;
    logic [1:0]  IRegStore;
    logic [3:0]  ALUOp;
    logic [15:0] IPCP2, OpA, OpB, IThirdArg;
    logic [2:0]  rdEx;
    logic        stall, ORegWrite, OMemWrite, OMemRead, ODataInSelect;
    logic [1:0]  ORegStore;
    logic [15:0] OPCP2, OALUResult, thirdArg;
    logic [2:0]  rdMem;

    execute_stage #(.WIDTH(16), .MUL_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .IValid(IValid), .IRegWrite(IRegWrite),
        .IMemWrite(IMemWrite), .IMemRead(IMemRead), .IDataInSelect(IDataInSelect),
        .IRegStore(IRegStore), .ALUOp(ALUOp), .IPCP2(IPCP2), .OpA(OpA), .OpB(OpB),
        .IThirdArg(IThirdArg), .rdEx(rdEx), .flush(flush), .stall(stall),
        .ORegWrite(ORegWrite), .OMemWrite(OMemWrite), .OMemRead(OMemRead),
        .ODataInSelect(ODataInSelect), .ORegStore(ORegStore), .OPCP2(OPCP2),
        .OALUResult(OALUResult), .thirdArg(thirdArg), .rdMem(rdMem)
    );

    always #5 clk = ~clk;

    logic [56:0] q_out[$];
    logic        q_stall[$];
    int          n_pass = 0;
    int          n_total = 0;
    bit          done_drv = 1'b0;

    // Monitor: compare stall for the current cycle and outputs after the last edge.
    initial begin
        logic [56:0] got, want;
        logic        ws;
        forever begin
            @(negedge clk);
            if (q_stall.size() > 0) begin
                ws = q_stall.pop_front();
                n_total++;
                if (stall === ws) n_pass++;
                else $display("FAIL stall @%0t: got %b want %b", $time, stall, ws);
            end
            if (q_out.size() > 0) begin
                want = q_out.pop_front();
                got  = {ORegWrite, OMemWrite, OMemRead, ODataInSelect, ORegStore,
                        OPCP2, OALUResult, thirdArg, rdMem};
                n_total++;
                if (got === want) n_pass++;
                else $display("FAIL exmem @%0t: got %h want %h (result got %h want %h)",
                              $time, got, want, OALUResult, want[34:19]);
            end
        end
    end

    // One cycle: drive inputs, queue expected stall now and outputs after the edge.
    task automatic step(input logic v, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [5:0] ctl, input logic [15:0] pc,
                        input logic [15:0] ta, input logic [2:0] rd, input logic f,
                        input logic rst, input logic exp_stall, input logic bubble,
                        input logic [15:0] exp_res);
        reset = rst; IValid = v; ALUOp = op; OpA = a; OpB = b;
        {IRegWrite, IMemWrite, IMemRead, IDataInSelect, IRegStore} = ctl;
        IPCP2 = pc; IThirdArg = ta; rdEx = rd; flush = f;
        q_stall.push_back(exp_stall);
        @(posedge clk); #1;
        q_out.push_back(bubble ? 57'd0 : {ctl, pc, exp_res, ta, rd});
    endtask

    // Full MUL held under stall: accept, 15 stalled iterations, product edge.
    task automatic mul_seq(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] prod, input logic [15:0] pc);
        step(1, 4'd9, a, b, 6'b100110, pc, 16'h5A5A, 3'd6, 0, 1, 1, 1, 0);
        for (int i = 0; i < 15; i++)
            step(1, 4'd9, a, b, 6'b100110, pc, 16'h5A5A, 3'd6, 0, 1, 1, 1, 0);
        step(1, 4'd9, a, b, 6'b100110, pc, 16'h5A5A, 3'd6, 0, 1, 0, 0, prod);
    endtask

    initial begin
        reset = 1'b0; IValid = 0; ALUOp = 0; OpA = 0; OpB = 0; IRegWrite = 0;
        IMemWrite = 0; IMemRead = 0; IDataInSelect = 0; IRegStore = 0; IPCP2 = 0;
        IThirdArg = 0; rdEx = 0; flush = 0;
        @(posedge clk); #1;
        // Held in reset with a valid ADD on the inputs.
        step(1, 4'd0, 16'h0004, 16'h0003, 6'b110101, 16'h0102, 16'hBEEF, 3'd3, 0, 0, 0, 1, 0);
        step(1, 4'd9, 16'h0004, 16'h0003, 6'b110101, 16'h0102, 16'hBEEF, 3'd3, 0, 0, 0, 1, 0);
        // ALU sweep
        step(1, 4'd0, 16'h0004, 16'h0003, 6'b110101, 16'h0102, 16'hBEEF, 3'd3, 0, 1, 0, 0, 16'h0007);
        step(1, 4'd1, 16'h0001, 16'h0002, 6'b001010, 16'h0104, 16'h1111, 3'd1, 0, 1, 0, 0, 16'hFFFF);
        step(1, 4'd7, 16'h8000, 16'h0004, 6'b100001, 16'h0106, 16'h2222, 3'd2, 0, 1, 0, 0, 16'hF800);
        step(1, 4'd8, 16'hFFFF, 16'h0001, 6'b100000, 16'h0108, 16'h3333, 3'd4, 0, 1, 0, 0, 16'h0001);
        step(1, 4'd8, 16'h0001, 16'hFFFF, 6'b100000, 16'h010A, 16'h3334, 3'd4, 0, 1, 0, 0, 16'h0000);
        step(1, 4'd12, 16'h1234, 16'h5678, 6'b111111, 16'h010C, 16'h4444, 3'd7, 0, 1, 0, 0, 16'h0000);
        step(1, 4'd2, 16'hF0F0, 16'h3C3C, 6'b100011, 16'h010E, 16'h0001, 3'd5, 0, 1, 0, 0, 16'h3030);
        step(1, 4'd3, 16'hF0F0, 16'h3C3C, 6'b100011, 16'h0110, 16'h0002, 3'd5, 0, 1, 0, 0, 16'hFCFC);
        step(1, 4'd4, 16'hF0F0, 16'h3C3C, 6'b100011, 16'h0112, 16'h0003, 3'd5, 0, 1, 0, 0, 16'hCCCC);
        step(1, 4'd5, 16'h0001, 16'h0013, 6'b100011, 16'h0114, 16'h0004, 3'd5, 0, 1, 0, 0, 16'h0008);
        step(1, 4'd6, 16'h8000, 16'h0004, 6'b100011, 16'h0116, 16'h0005, 3'd5, 0, 1, 0, 0, 16'h0800);
        // Invalid slot and flush in IDLE both give a bubble
        step(0, 4'd0, 16'h0001, 16'h0001, 6'b111111, 16'h0118, 16'h0006, 3'd1, 0, 1, 0, 1, 0);
        step(1, 4'd0, 16'h0001, 16'h0001, 6'b111111, 16'h011A, 16'h0007, 3'd1, 1, 1, 0, 1, 0);
        step(1, 4'd9, 16'h0001, 16'h0001, 6'b111111, 16'h011C, 16'h0008, 3'd1, 1, 1, 0, 1, 0);
        // MUL then ADD accepted at E17, then overflow MUL back to back
        mul_seq(16'h0123, 16'h0045, 16'h4E6F, 16'h0200);
        step(1, 4'd0, 16'h1000, 16'h0234, 6'b010000, 16'h0202, 16'h9999, 3'd2, 0, 1, 0, 0, 16'h1234);
        mul_seq(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0204);
        mul_seq(16'h00FF, 16'h0101, 16'hFFFF, 16'h0206);
        // Flush at count 7
        step(1, 4'd9, 16'h0123, 16'h0045, 6'b100110, 16'h0300, 16'h5A5A, 3'd6, 0, 1, 1, 1, 0);
        for (int i = 0; i < 7; i++)
            step(1, 4'd9, 16'h0123, 16'h0045, 6'b100110, 16'h0300, 16'h5A5A, 3'd6, 0, 1, 1, 1, 0);
        step(1, 4'd9, 16'h0123, 16'h0045, 6'b100110, 16'h0300, 16'h5A5A, 3'd6, 1, 1, 0, 1, 0);
        step(1, 4'd0, 16'h0020, 16'h0003, 6'b101010, 16'h0302, 16'h7777, 3'd3, 0, 1, 0, 0, 16'h0023);
        // Reset at count 5
        step(1, 4'd9, 16'h0123, 16'h0045, 6'b100110, 16'h0400, 16'h5A5A, 3'd6, 0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            step(1, 4'd9, 16'h0123, 16'h0045, 6'b100110, 16'h0400, 16'h5A5A, 3'd6, 0, 1, 1, 1, 0);
        step(1, 4'd9, 16'h0123, 16'h0045, 6'b100110, 16'h0400, 16'h5A5A, 3'd6, 0, 0, 0, 1, 0);
        mul_seq(16'h0002, 16'h0003, 16'h0006, 16'h0402);
        step(0, 4'd0, 16'h0000, 16'h0000, 6'b000000, 16'h0000, 16'h0000, 3'd0, 0, 1, 0, 1, 0);
        @(negedge clk); @(negedge clk);
        done_drv = 1'b1;
        n_total++;
        if (q_out.size() == 0 && q_stall.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", q_out.size() + q_stall.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
